wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 34 +++
 rtl/wb_regfile_pend_counter.sv | 27 ++
 rtl/wb_regfile.sv | 97 +++++++++
 tb/tb_wb_regfile.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared sizing, byte-lane encodings and the write-back merge rule for the
// register file with per-register pending scoreboard.
package wb_regfile_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] BP_LO = 2'b00;
    localparam logic [1:0] BP_HI = 2'b01;

    // Value a register holds after a write-back; reserved lanes leave it untouched.
    function automatic logic [DATA_W-1:0] merge_wb(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] wb_val,
        input logic              word,
        input logic [1:0]        lane
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        if (word) begin
            res = wb_val;
        end else if (lane == BP_LO) begin
            res = {old_val[DATA_W-1:8], wb_val[7:0]};
        end else if (lane == BP_HI) begin
            res = {wb_val[7:0], old_val[7:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_regfile_pend_counter.sv
// Saturating up/down pending-write counter for one register.
// underflow flags a decrement arriving while the count is already zero.
module pend_counter
    import wb_regfile_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow
);

    assign underflow = dec && (cnt == '0);

    // Simultaneous inc and dec cancel, including at the saturation limits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Register file with write-through bypass and a per-register pending-write
// scoreboard that stalls decode on RAW hazards and counter saturation.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           wb_result,
    input  logic [ADDR_W-1:0]           destReg_addr,
    input  logic                        we,
    input  logic                        word_access,
    input  logic [1:0]                  bp,
    input  logic [ADDR_W-1:0]           rs1_addr,
    input  logic [ADDR_W-1:0]           rs2_addr,
    input  logic                        rs1_used,
    input  logic                        rs2_used,
    output logic [DATA_W-1:0]           rs1_data,
    output logic [DATA_W-1:0]           rs2_data,
    input  logic                        issue_valid,
    input  logic [ADDR_W-1:0]           issue_dest,
    output logic                        stall,
    output logic                        sb_err,
    output logic [NREGS-1:0][CNT_W-1:0] dbg_cnt
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [CNT_W-1:0]  cnt  [NREGS];
    logic [CNT_W-1:0]  eff  [NREGS];
    logic [NREGS-1:0]  inc_vec;
    logic [NREGS-1:0]  dec_vec;
    logic [NREGS-1:0]  uflow_vec;
    logic [DATA_W-1:0] wb_merged;
    logic              bad_lane;
    logic              rs1_hazard;
    logic              rs2_hazard;
    logic              issue_full;
    logic              stall_raw;
    logic              sb_err_q;

    assign wb_merged = merge_wb(regs[destReg_addr], wb_result, word_access, bp);
    assign bad_lane  = we && !word_access && bp[1];

    // Issue/stall contract: an issue is accepted on a rising edge only when
    // issue_valid=1 and stall=0; decode holds its inputs while stall=1.
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        assign dec_vec[r] = we && (destReg_addr == ADDR_W'(r));
        assign inc_vec[r] = issue_valid && !stall_raw && (issue_dest == ADDR_W'(r));

        pend_counter u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc_vec[r]),
            .dec       (dec_vec[r]),
            .cnt       (cnt[r]),
            .underflow (uflow_vec[r])
        );

        assign eff[r]     = (dec_vec[r] && (cnt[r] != '0)) ? cnt[r] - CNT_W'(1) : cnt[r];
        assign dbg_cnt[r] = cnt[r];
    end

    assign rs1_hazard = rs1_used && (eff[rs1_addr] != '0);
    assign rs2_hazard = rs2_used && (eff[rs2_addr] != '0);
    assign issue_full = issue_valid && (cnt[issue_dest] == CNT_MAX) && !dec_vec[issue_dest];
    assign stall_raw  = rs1_hazard || rs2_hazard || issue_full;
    assign stall      = reset && stall_raw;

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (reset) begin
            rs1_data = (we && (destReg_addr == rs1_addr)) ? wb_merged : regs[rs1_addr];
            rs2_data = (we && (destReg_addr == rs2_addr)) ? wb_merged : regs[rs2_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[destReg_addr] <= wb_merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_err_q <= 1'b0;
        end else if (bad_lane || (|uflow_vec)) begin
            sb_err_q <= 1'b1;
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_wb_regfile;

    logic            clk = 1'b0;
    logic            reset;
    logic [15:0]     wb_result;
    logic [2:0]      destReg_addr;
    logic            we;
    logic            word_access;
    logic [1:0]      bp;
    logic [2:0]      rs1_addr;
    logic [2:0]      rs2_addr;
    logic            rs1_used;
    logic            rs2_used;
    logic [15:0]     rs1_data;
    logic [15:0]     rs2_data;
    logic            issue_valid;
    logic [2:0]      issue_dest;
    logic            stall;
    logic            sb_err;
    logic [7:0][1:0] dbg_cnt;

    int          n_checks = 0;
    int          n_err    = 0;

    logic [15:0] m_reg [8];
    int          m_cnt [8];
    bit          m_err;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk          (clk),
        .reset        (reset),
        .wb_result    (wb_result),
        .destReg_addr (destReg_addr),
        .we           (we),
        .word_access  (word_access),
        .bp           (bp),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_used     (rs1_used),
        .rs2_used     (rs2_used),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .issue_valid  (issue_valid),
        .issue_dest   (issue_dest),
        .stall        (stall),
        .sb_err       (sb_err),
        .dbg_cnt      (dbg_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [15:0] model_merge(input logic [15:0] old);
        if (word_access) return wb_result;
        if (bp == 2'b00) return {old[15:8], wb_result[7:0]};
        if (bp == 2'b01) return {wb_result[7:0], old[7:0]};
        return old;
    endfunction

    function automatic logic [15:0] model_read(input logic [2:0] a);
        if (!reset) return 16'h0000;
        if (we && destReg_addr == a) return model_merge(m_reg[a]);
        return m_reg[a];
    endfunction

    function automatic int model_eff(input int r);
        if (we && destReg_addr == 3'(r) && m_cnt[r] > 0) return m_cnt[r] - 1;
        return m_cnt[r];
    endfunction

    function automatic bit model_stall();
        if (!reset) return 1'b0;
        if (rs1_used && model_eff(int'(rs1_addr)) != 0) return 1'b1;
        if (rs2_used && model_eff(int'(rs2_addr)) != 0) return 1'b1;
        if (issue_valid && m_cnt[issue_dest] == 3 && !(we && destReg_addr == issue_dest)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_reg[i] = 16'h0000;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
    endtask

    // Applied at the rising edge, using the inputs that were stable before it.
    task automatic model_update();
        bit          s;
        logic [15:0] nv;
        int          d;
        if (!reset) begin
            model_clear();
            return;
        end
        s  = model_stall();
        nv = model_merge(m_reg[destReg_addr]);
        for (int r = 0; r < 8; r++) begin
            d = m_cnt[r];
            if (issue_valid && !s && issue_dest == 3'(r)) d++;
            if (we && destReg_addr == 3'(r)) begin
                if (m_cnt[r] == 0) m_err = 1'b1;
                d--;
            end
            if (d < 0) d = 0;
            if (d > 3) d = 3;
            m_cnt[r] = d;
        end
        if (we) begin
            if (!word_access && bp[1]) m_err = 1'b1;
            m_reg[destReg_addr] = nv;
        end
    endtask

    task automatic check_model();
        chk("rs1_data", 32'(rs1_data), 32'(model_read(rs1_addr)));
        chk("rs2_data", 32'(rs2_data), 32'(model_read(rs2_addr)));
        chk("stall", 32'(stall), 32'(model_stall()));
        chk("sb_err", 32'(sb_err), reset ? 32'(m_err) : 32'd0);
        for (int r = 0; r < 8; r++) begin
            chk("cnt", 32'(dbg_cnt[r]), reset ? 32'(m_cnt[r]) : 32'd0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        we = 1'b0; word_access = 1'b1; bp = 2'b00; wb_result = 16'h0000;
        destReg_addr = 3'd0; rs1_addr = 3'd0; rs2_addr = 3'd0;
        rs1_used = 1'b0; rs2_used = 1'b0; issue_valid = 1'b0; issue_dest = 3'd0;
    endtask

    task automatic settle();
        #1;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic wb_word(input logic [2:0] d, input logic [15:0] v);
        we = 1'b1; word_access = 1'b1; destReg_addr = d; wb_result = v;
    endtask

    task automatic wb_byte(input logic [2:0] d, input logic [1:0] lane, input logic [15:0] v);
        we = 1'b1; word_access = 1'b0; bp = lane; destReg_addr = d; wb_result = v;
    endtask

    task automatic issue(input logic [2:0] d);
        issue_valid = 1'b1; issue_dest = d;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        settle();
        tick();
        reset = 1'b1;
        settle();
    endtask

    initial begin
        idle();
        model_clear();
        reset = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state: every register reads zero, no stall.
        for (int i = 0; i < 8; i++) begin
            idle();
            rs1_addr = 3'(i); rs2_addr = 3'(7 - i); rs1_used = 1'b1; rs2_used = 1'b1;
            settle();
            chk("reset_rd", 32'(rs1_data), 32'h0000);
            chk("reset_stall", 32'(stall), 32'd0);
            tick();
        end

        // Word write with same-cycle bypass, then from register state.
        idle(); issue(3'd3); settle(); tick();
        idle(); wb_word(3'd3, 16'hBEEF); rs1_addr = 3'd3; settle();
        chk("bypass_beef", 32'(rs1_data), 32'hBEEF);
        tick();
        idle(); rs1_addr = 3'd3; settle();
        chk("state_beef", 32'(rs1_data), 32'hBEEF);
        tick();

        // Byte lanes on r5; the word write also carries a fourth issue.
        for (int i = 0; i < 3; i++) begin
            idle(); issue(3'd5); settle(); tick();
        end
        idle(); wb_word(3'd5, 16'h1234); issue(3'd5); settle();
        chk("full_issue_dec", 32'(stall), 32'd0);
        tick();
        chk("cnt5_held", 32'(dbg_cnt[5]), 32'd3);
        idle(); wb_byte(3'd5, 2'b01, 16'h00AB); settle(); tick();
        idle(); rs2_addr = 3'd5; settle();
        chk("byte_hi", 32'(rs2_data), 32'hAB34);
        wb_byte(3'd5, 2'b00, 16'h00CD); settle(); tick();
        idle(); rs2_addr = 3'd5; settle();
        chk("byte_lo", 32'(rs2_data), 32'hABCD);
        chk("no_err_yet", 32'(sb_err), 32'd0);
        wb_byte(3'd5, 2'b10, 16'h00EE); settle(); tick();
        idle(); rs2_addr = 3'd5; settle();
        chk("byte_rsv", 32'(rs2_data), 32'hABCD);
        chk("rsv_err", 32'(sb_err), 32'd1);
        tick();

        do_reset();

        // RAW hazard on r2 released by a same-cycle write-back.
        idle(); issue(3'd2); settle(); tick();
        idle(); rs1_addr = 3'd2; rs1_used = 1'b1; settle();
        chk("raw_stall", 32'(stall), 32'd1);
        tick();
        wb_word(3'd2, 16'h5A5A); settle();
        chk("raw_release", 32'(stall), 32'd0);
        chk("raw_bypass", 32'(rs1_data), 32'h5A5A);
        tick();

        // Counter saturation on r4.
        for (int i = 0; i < 3; i++) begin
            idle(); issue(3'd4); settle(); tick();
        end
        idle(); issue(3'd4); settle();
        chk("sat_stall", 32'(stall), 32'd1);
        tick();
        chk("sat_cnt", 32'(dbg_cnt[4]), 32'd3);
        idle(); issue(3'd4); wb_word(3'd4, 16'h4444); settle();
        chk("sat_accept", 32'(stall), 32'd0);
        tick();
        chk("sat_cnt2", 32'(dbg_cnt[4]), 32'd3);
        for (int i = 0; i < 3; i++) begin
            idle(); wb_word(3'd4, 16'h4400 + 16'(i)); settle(); tick();
        end
        chk("drained", 32'(dbg_cnt[4]), 32'd0);
        chk("drain_ok", 32'(sb_err), 32'd0);

        // Underflow on r6, then an asynchronous reset mid-cycle with pending r1.
        idle(); issue(3'd1); wb_word(3'd6, 16'h6666); settle(); tick();
        idle(); rs2_addr = 3'd6; settle();
        chk("uflow_data", 32'(rs2_data), 32'h6666);
        chk("uflow_cnt", 32'(dbg_cnt[6]), 32'd0);
        chk("uflow_err", 32'(sb_err), 32'd1);
        reset = 1'b0;
        settle();
        chk("arst_err", 32'(sb_err), 32'd0);
        chk("arst_rd", 32'(rs2_data), 32'h0000);
        chk("arst_cnt1", 32'(dbg_cnt[1]), 32'd0);
        tick();
        reset = 1'b1;
        settle();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            int pick;
            reset        = ($urandom_range(0, 149) != 0);
            we           = ($urandom_range(0, 2) == 0);
            word_access  = $urandom_range(0, 1);
            bp           = ($urandom_range(0, 15) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
            wb_result    = 16'($urandom);
            destReg_addr = 3'($urandom_range(0, 7));
            pick = $urandom_range(0, 7);
            for (int k = 0; k < 8; k++) begin
                if (m_cnt[(pick + k) % 8] > 0 && $urandom_range(0, 9) != 0) begin
                    destReg_addr = 3'((pick + k) % 8);
                    break;
                end
            end
            rs1_addr     = 3'($urandom_range(0, 7));
            rs2_addr     = 3'($urandom_range(0, 7));
            rs1_used     = $urandom_range(0, 1);
            rs2_used     = $urandom_range(0, 1);
            issue_valid  = ($urandom_range(0, 2) != 0);
            issue_dest   = 3'($urandom_range(0, 7));
            settle();
            tick();
        end

        idle();
        settle();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
